// File: rtl/uart_print_pkg.sv
// Shared types and constants for the UART print buffer.
package uart_print_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT_BUSY,
    WAIT_DONE
  } tx_state_e;

  localparam logic [BYTE_W-1:0] CHAR_LF = 8'h0A;
  localparam logic [BYTE_W-1:0] CHAR_CR = 8'h0D;

endpackage

// File: rtl/print_byte_fifo.sv
// Synchronous byte FIFO with a combinational head; pointers carry one wrap bit.
module print_byte_fifo
  import uart_print_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  localparam int unsigned PTR_W = $clog2(DEPTH) + 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [BYTE_W-1:0] wdata_i,
  output logic [BYTE_W-1:0] rdata_c_o,
  output logic              full_c_o,
  output logic              empty_c_o,
  output logic [PTR_W-1:0]  level_c_o
);

  localparam int unsigned AW = PTR_W - 1;

  logic [BYTE_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic              do_push, do_pop;

  // Equal index with differing wrap bit means full.
  assign empty_c_o = (wr_ptr_q == rd_ptr_q);
  assign full_c_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign level_c_o = wr_ptr_q - rd_ptr_q;
  assign rdata_c_o = mem_q[rd_ptr_q[AW-1:0]];

  assign do_pop  = pop_i & ~empty_c_o;
  assign do_push = push_i & (~full_c_o | do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
    rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset; occupancy is defined by the pointers alone.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end
  end

endmodule

// File: rtl/uart_print_buffer.sv
// Queues print-port bytes and sequences them into the Uart8 transmitter.
// Define UART_PRINT_CRLF_EN to expand each LF into a CR,LF pair on the wire.
module uart_print_buffer
  import uart_print_pkg::*;
#(
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned DROP_CNT_W = 16,
  localparam int unsigned LVL_W     = $clog2(DEPTH) + 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  print_valid_i,
  input  logic [31:0]           print_wdata_i,
  output logic                  tx_start_o,
  output logic [BYTE_W-1:0]     tx_data_o,
  input  logic                  tx_busy_i,
  input  logic                  tx_done_i,
  output logic [LVL_W-1:0]      fifo_level_o,
  output logic                  overflow_o,
  output logic [DROP_CNT_W-1:0] drop_count_o
);

  tx_state_e             state_q, state_d;
  logic                  tx_start_q, tx_start_d;
  logic [BYTE_W-1:0]     tx_data_q, tx_data_d;
  logic [DROP_CNT_W-1:0] drop_q, drop_d;
  logic                  ovf_q, ovf_d;

  logic                  pop_c, load_c, push_c, drop_c;
  logic                  fifo_full, fifo_empty;
  logic [BYTE_W-1:0]     fifo_head;
  logic                  wdata_unused;

  assign wdata_unused = ^print_wdata_i[31:BYTE_W];

  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push_c = print_valid_i & (~fifo_full | pop_c);
  assign drop_c = print_valid_i & fifo_full & ~pop_c;

  print_byte_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .push_i   (push_c),
    .pop_i    (pop_c),
    .wdata_i  (print_wdata_i[BYTE_W-1:0]),
    .rdata_c_o(fifo_head),
    .full_c_o (fifo_full),
    .empty_c_o(fifo_empty),
    .level_c_o(fifo_level_o)
  );

`ifdef UART_PRINT_CRLF_EN
  logic cr_sent_q, cr_sent_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cr_sent_q <= 1'b0;
    end else begin
      cr_sent_q <= cr_sent_d;
    end
  end
`endif

  // Transmit sequencer: next state, pop and registered UART drive.
  always_comb begin
    state_d    = state_q;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    pop_c      = 1'b0;
    load_c     = 1'b0;
`ifdef UART_PRINT_CRLF_EN
    cr_sent_d  = cr_sent_q;
`endif

    unique case (state_q)
      IDLE: begin
        load_c = ~fifo_empty;
      end
      START: begin
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        // A done without a visible busy phase still ends the frame.
        if (tx_done_i) begin
          state_d = IDLE;
          load_c  = ~fifo_empty;
        end else if (tx_busy_i) begin
          state_d = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (tx_done_i) begin
          state_d = IDLE;
          load_c  = ~fifo_empty;
        end
      end
      default: state_d = IDLE;
    endcase

    if (load_c) begin
      state_d    = START;
      tx_start_d = 1'b1;
`ifdef UART_PRINT_CRLF_EN
      // LF stays at the head until the inserted CR frame has completed.
      if ((fifo_head == CHAR_LF) && !cr_sent_q) begin
        tx_data_d = CHAR_CR;
        cr_sent_d = 1'b1;
      end else begin
        tx_data_d = fifo_head;
        pop_c     = 1'b1;
        cr_sent_d = 1'b0;
      end
`else
      tx_data_d = fifo_head;
      pop_c     = 1'b1;
`endif
    end
  end

  // Saturating drop counter and sticky overflow flag.
  always_comb begin
    drop_d = drop_q;
    ovf_d  = ovf_q;
    if (drop_c) begin
      ovf_d = 1'b1;
      if (drop_q != {DROP_CNT_W{1'b1}}) begin
        drop_d = drop_q + DROP_CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
      drop_q     <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      drop_q     <= drop_d;
      ovf_q      <= ovf_d;
    end
  end

  assign tx_start_o   = tx_start_q;
  assign tx_data_o    = tx_data_q;
  assign overflow_o   = ovf_q;
  assign drop_count_o = drop_q;

endmodule

// File: tb/tb_uart_print_buffer.sv
// Scoreboard bench for uart_print_buffer with a UART responder and a queue-level reference model.
module tb_uart_print_buffer;
  import uart_print_pkg::*;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        print_valid = 1'b0;
  logic [31:0] print_wdata = '0;
  logic        tx_busy = 1'b0;
  logic        tx_done = 1'b0;

  logic             tx_start, s_tx_start;
  logic [7:0]       tx_data, s_tx_data;
  logic [LVL_W-1:0] fifo_level, s_level;
  logic             overflow, s_overflow;
  logic [15:0]      drop_count;
  logic [1:0]       s_drop;

  always #5 clk = ~clk;

  uart_print_buffer #(.DEPTH(DEPTH), .DROP_CNT_W(16)) u_dut (
    .clk_i(clk), .rst_ni(rst_ni), .print_valid_i(print_valid), .print_wdata_i(print_wdata),
    .tx_start_o(tx_start), .tx_data_o(tx_data), .tx_busy_i(tx_busy), .tx_done_i(tx_done),
    .fifo_level_o(fifo_level), .overflow_o(overflow), .drop_count_o(drop_count)
  );

  // Narrow-counter instance sharing all stimulus, used for saturation.
  uart_print_buffer #(.DEPTH(DEPTH), .DROP_CNT_W(2)) u_dut_sat (
    .clk_i(clk), .rst_ni(rst_ni), .print_valid_i(print_valid), .print_wdata_i(print_wdata),
    .tx_start_o(s_tx_start), .tx_data_o(s_tx_data), .tx_busy_i(tx_busy), .tx_done_i(tx_done),
    .fifo_level_o(s_level), .overflow_o(s_overflow), .drop_count_o(s_drop)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- UART responder ----------------
  logic u_active = 1'b0;
  int   u_cnt = 0;
  logic stall = 1'b0;
  logic force_done = 1'b0;
  logic busy_rand = 1'b0;
  int   frame_min = 2;
  int   frame_max = 4;

  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (!rst_ni) begin
        tx_busy  = 1'b0;
        tx_done  = 1'b0;
        u_active = 1'b0;
      end else begin
        if (tx_done) tx_done = 1'b0;
        if (force_done && u_active) begin
          tx_done    = 1'b1;
          tx_busy    = 1'b0;
          u_active   = 1'b0;
          force_done = 1'b0;
        end else if (tx_start) begin
          u_active = 1'b1;
          u_cnt    = $urandom_range(frame_max, frame_min);
          tx_busy  = (busy_rand && ($urandom_range(1) == 0)) ? 1'b0 : 1'b1;
        end else if (u_active) begin
          if (u_cnt > 0) u_cnt--;
          else if (!stall) begin
            tx_done  = 1'b1;
            tx_busy  = 1'b0;
            u_active = 1'b0;
          end
        end
      end
    end
  end

  // ---------------- Reference model ----------------
  // Queue of buffered bytes; a frame is "active" from its start until the UART reports done.
  logic [7:0] mq[$];
  logic [7:0] sb[$];
  int   m_drops = 0;
  bit   m_ovf = 1'b0;
  bit   m_active = 1'b0;
  bit   m_fresh = 1'b0;
  bit   m_cr = 1'b0;
  bit   m_over, m_take;

  always @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      mq.delete();
      sb.delete();
      m_drops  = 0;
      m_ovf    = 1'b0;
      m_active = 1'b0;
      m_fresh  = 1'b0;
      m_cr     = 1'b0;
    end else begin
      m_over = m_active && !m_fresh && tx_done;
      m_take = (!m_active || m_over) && (mq.size() > 0);
      if (m_take) begin
`ifdef UART_PRINT_CRLF_EN
        if (mq[0] == CHAR_LF && !m_cr) begin
          sb.push_back(CHAR_CR);
          m_cr = 1'b1;
        end else begin
          sb.push_back(mq.pop_front());
          m_cr = 1'b0;
        end
`else
        sb.push_back(mq.pop_front());
`endif
      end
      if (print_valid) begin
        if (mq.size() < DEPTH) mq.push_back(print_wdata[7:0]);
        else begin
          m_drops++;
          m_ovf = 1'b1;
        end
      end
      m_fresh  = m_take;
      m_active = m_take ? 1'b1 : (m_over ? 1'b0 : m_active);
    end
  end

  // ---------------- Monitor ----------------
  int         n_tx = 0;
  int         peak = 0;
  logic [7:0] prev_data = '0;
  logic       prev_busy = 1'b0;

  always @(negedge clk) begin
    check("level", 32'(fifo_level), 32'(mq.size()));
    check("sat_level", 32'(s_level), 32'(mq.size()));
    check("tx_start", 32'(tx_start), 32'(m_fresh));
    check("sat_tx_start", 32'(s_tx_start), 32'(m_fresh));
    check("drop_count", 32'(drop_count), 32'(m_drops));
    check("sat_drop_count", 32'(s_drop), 32'((m_drops > 3) ? 3 : m_drops));
    check("overflow", 32'(overflow), 32'(m_ovf));
    check("sat_overflow", 32'(s_overflow), 32'(m_ovf));
    if (tx_start) begin
      n_tx++;
      if (sb.size() == 0) check("tx_expected", 32'd0, 32'd1);
      else check("tx_data", 32'(tx_data), 32'(sb.pop_front()));
    end
    if (prev_busy && tx_busy) check("data_stable_busy", 32'(tx_data), 32'(prev_data));
    if (32'(fifo_level) > 32'(peak)) peak = int'(fifo_level);
    prev_data = tx_data;
    prev_busy = tx_busy;
  end

  // ---------------- Stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [7:0] b);
    print_valid = 1'b1;
    print_wdata = {24'($urandom()), b};
    cyc(1);
    print_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if (mq.size() == 0 && !m_active) begin
        ok = 1'b1;
        break;
      end
      cyc(1);
    end
    check(name, 32'(ok), 32'd1);
    cyc(2);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_tx_start"}, 32'(tx_start), 32'd0);
    check({tag, "_tx_data"}, 32'(tx_data), 32'd0);
    check({tag, "_level"}, 32'(fifo_level), 32'd0);
    check({tag, "_overflow"}, 32'(overflow), 32'd0);
    check({tag, "_drop"}, 32'(drop_count), 32'd0);
  endtask

  int base;

  initial begin
    #12;
    check_all_zero("reset");
    @(posedge clk);
    #1;
    rst_ni = 1'b1;
    cyc(2);

    // Single byte latency.
    push(8'h41);
    check("single_level", 32'(fifo_level), 32'd1);
    check("single_nostart", 32'(tx_start), 32'd0);
    cyc(1);
    check("single_start", 32'(tx_start), 32'd1);
    check("single_data", 32'(tx_data), 32'h41);
    cyc(1);
    check("single_pulse", 32'(tx_start), 32'd0);
    drain("single_drain");

    // Burst of 16 with long frames.
    frame_min = 30; frame_max = 30;
    peak = 0;
    base = n_tx;
    for (int i = 0; i < 16; i++) begin
      print_valid = 1'b1;
      print_wdata = {24'($urandom()), 8'(8'h30 + i)};
      cyc(1);
    end
    print_valid = 1'b0;
    drain("burst_drain");
    check("burst_peak", 32'(peak), 32'd15);
    check("burst_ntx", 32'(n_tx - base), 32'd16);
    check("burst_nodrop", 32'(drop_count), 32'd0);

    // Overflow with the UART stalled, then saturation of the narrow counter.
    frame_min = 2; frame_max = 2;
    stall = 1'b1;
    base = n_tx;
    for (int i = 0; i < 20; i++) begin
      print_valid = 1'b1;
      print_wdata = {24'($urandom()), 8'(8'h50 + i)};
      cyc(1);
    end
    print_valid = 1'b0;
    cyc(3);
    check("ovf_drop", 32'(drop_count), 32'd3);
    check("ovf_flag", 32'(overflow), 32'd1);
    check("ovf_level", 32'(fifo_level), 32'd16);
    for (int i = 0; i < 3; i++) push(8'h77);
    check("sat_main_drop", 32'(drop_count), 32'd6);
    check("sat_drop", 32'(s_drop), 32'd3);

    // Push into a full FIFO in the same cycle as the done-driven pop.
    force_done  = 1'b1;
    print_valid = 1'b1;
    print_wdata = {24'($urandom()), 8'h99};
    cyc(1);
    print_valid = 1'b0;
    check("fullpop_level", 32'(fifo_level), 32'd16);
    check("fullpop_drop", 32'(drop_count), 32'd6);
    stall = 1'b0;
    drain("ovf_drain");
    check("ovf_ntx", 32'(n_tx - base), 32'd18);

    // Line feed handling.
    frame_min = 3; frame_max = 3;
    peak = 0;
    base = n_tx;
    push(CHAR_LF);
    drain("lf_drain");
    check("lf_peak", 32'(peak <= 1), 32'd1);
`ifdef UART_PRINT_CRLF_EN
    check("lf_ntx", 32'(n_tx - base), 32'd2);
`else
    check("lf_ntx", 32'(n_tx - base), 32'd1);
`endif

    // Random traffic: light then heavy, with optional busy-less frames.
    busy_rand = 1'b1;
    frame_min = 0; frame_max = 6;
    for (int i = 0; i < 400; i++) begin
      print_valid = ($urandom_range(99) < 40);
      print_wdata = {24'($urandom()), ($urandom_range(7) == 0) ? CHAR_LF : 8'($urandom())};
      cyc(1);
    end
    frame_min = 4; frame_max = 8;
    for (int i = 0; i < 150; i++) begin
      print_valid = ($urandom_range(99) < 90);
      print_wdata = {24'($urandom()), ($urandom_range(7) == 0) ? CHAR_LF : 8'($urandom())};
      cyc(1);
    end
    print_valid = 1'b0;
    drain("rand_drain");
    busy_rand = 1'b0;

    // Reset while waiting for done with five bytes queued.
    frame_min = 2; frame_max = 2;
    stall = 1'b1;
    for (int i = 0; i < 6; i++) begin
      print_valid = 1'b1;
      print_wdata = {24'($urandom()), 8'(8'h61 + i)};
      cyc(1);
    end
    print_valid = 1'b0;
    cyc(4);
    check("rst_pre_level", 32'(fifo_level), 32'd5);
    rst_ni = 1'b0;
    #1;
    check_all_zero("midrst");
    cyc(2);
    rst_ni = 1'b1;
    stall = 1'b0;
    base = n_tx;
    cyc(20);
    check("rst_no_start", 32'(n_tx - base), 32'd0);
    push(8'h42);
    drain("rst_drain");
    check("rst_ntx", 32'(n_tx - base), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not complete, got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
